// File: rtl/tt_um_logic_accumulator_if.sv
// Tiny Tapeout pin bundle for the logic accumulator tile.
// The tile drives the master-side inputs from the slave side.
interface tt_um_logic_accumulator_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_logic_accumulator.sv
// Registered bitwise AND/OR/XOR/XNOR unit with a bounded fold accumulator.
// A synchronised strobe edge loads op(A,B) or folds op(res,A) into the held result.
module tt_um_logic_accumulator #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tt_um_logic_accumulator_if.slave    pins
);
    localparam int             CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

    function automatic logic [WIDTH-1:0] f_op(
        input logic [1:0]       mode,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        case (mode)
            2'b00:   f_op = x & y;
            2'b01:   f_op = x | y;
            2'b10:   f_op = x ^ y;
            2'b11:   f_op = ~(x ^ y);
            default: f_op = {WIDTH{1'b0}};
        endcase
    endfunction

    logic              r_s1;
    logic              r_s2;
    logic              r_prev;
    logic [WIDTH-1:0]  r_res;
    logic [CW-1:0]     r_cnt;
    logic              r_valid;

    logic [WIDTH-1:0]  w_op_a;
    logic [WIDTH-1:0]  w_op_b;
    logic              w_acc;
    logic [1:0]        w_mode;
    logic              w_fire;
    logic              w_done;
    logic [WIDTH-1:0]  w_res_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_valid_nxt;
    logic [7:0]        w_res_ext;
    logic              w_unused;

    assign w_op_a   = pins.ui_in[WIDTH-1:0];
    assign w_op_b   = pins.uio_in[WIDTH-1:0];
    assign w_acc    = pins.ui_in[6];
    assign w_mode   = pins.uio_in[7:6];
    assign w_fire   = r_s2 & ~r_prev;
    assign w_done   = (r_cnt == CNT_FULL);
    assign w_unused = ^{pins.ena, pins.ui_in, pins.uio_in};

    // Strobe synchroniser and edge history; preset high so a strobe held through reset cannot fire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= pins.ui_in[7];
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // Next result/count/valid: load, fold while not full, otherwise hold.
    always_comb begin
        w_res_nxt   = r_res;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        if (w_fire) begin
            if (!w_acc) begin
                w_res_nxt   = f_op(w_mode, w_op_a, w_op_b);
                w_cnt_nxt   = CW'(1'b1);
                w_valid_nxt = 1'b1;
            end else if (r_cnt != CNT_FULL) begin
                w_res_nxt   = f_op(w_mode, r_res, w_op_a);
                w_cnt_nxt   = r_cnt + CW'(1'b1);
                w_valid_nxt = 1'b1;
            end else begin
                w_res_nxt   = r_res;
                w_cnt_nxt   = r_cnt;
                w_valid_nxt = r_valid;
            end
        end else begin
            w_res_nxt   = r_res;
            w_cnt_nxt   = r_cnt;
            w_valid_nxt = r_valid;
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res   <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_res   <= w_res_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Zero-extend the result into the low output byte.
    always_comb begin
        w_res_ext             = 8'h00;
        w_res_ext[WIDTH-1:0]  = r_res;
    end

    assign pins.uo_out  = {w_done, r_valid, w_res_ext[5:0]};
    assign pins.uio_out = 8'h00;
    assign pins.uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_logic_accumulator.sv
// Scoreboard bench for tt_um_logic_accumulator: stimulus queues expected uo_out per cycle,
// a monitor compares at the falling edge of the due cycle.
module tb_tt_um_logic_accumulator;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        int         due;
        logic [7:0] exp;
        string      nm;
    } sb_item_t;

    sb_item_t sb[$];

    tt_um_logic_accumulator_if pins();

    tt_um_logic_accumulator #(.WIDTH(6), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (pins.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: pop every entry due this cycle; an entry whose cycle has passed counts as missed.
    initial begin
        sb_item_t it;
        n_tests = 0;
        n_fail  = 0;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                it = sb.pop_front();
                n_tests = n_tests + 1;
                if (it.due != cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: check missed (due %0d, now %0d), required uo_out=%02h",
                             it.nm, it.due, cyc, it.exp);
                end else if ({pins.uio_oe, pins.uio_out, pins.uo_out} !== {16'h0000, it.exp}) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: got uo_out=%02h uio_out=%02h uio_oe=%02h, required %02h/00/00",
                             it.nm, pins.uo_out, pins.uio_out, pins.uio_oe, it.exp);
                end
            end
        end
    end

    task automatic push(input int due, input logic [7:0] exp, input string nm);
        sb_item_t it;
        it.due = due;
        it.exp = exp;
        it.nm  = nm;
        sb.push_back(it);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        push(cyc + 1, 8'h00, {nm, "_r1"});
        push(cyc + 2, 8'h00, {nm, "_r2"});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Operands settle 3 cycles, strobe rises; result must be old at edge k+1, new at edge k+2.
    task automatic pulse(input logic [7:0] ui, input logic [7:0] uio,
                         input logic [7:0] exp_old, input logic [7:0] exp_new,
                         input string nm);
        @(negedge clk);
        pins.ui_in  = {1'b0, ui[6:0]};
        pins.uio_in = uio;
        repeat (3) @(negedge clk);
        pins.ui_in[7] = 1'b1;
        push(cyc + 2, exp_old, {nm, "_pre"});
        push(cyc + 3, exp_new, nm);
        repeat (4) @(negedge clk);
        pins.ui_in[7] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int c;
        rst_n       = 1'b0;
        pins.ena    = 1'b1;
        pins.ui_in  = 8'h5A;
        pins.uio_in = 8'hC3;

        do_reset("reset");
        pins.ui_in  = 8'h00;
        pins.uio_in = 8'h00;

        // Single loads, A=0x2D B=0x1B
        pulse(8'h2D, 8'h1B, 8'h00, 8'h49, "and");
        pulse(8'h2D, 8'h5B, 8'h49, 8'h7F, "or");
        pulse(8'h2D, 8'h9B, 8'h7F, 8'h76, "xor");
        pulse(8'h2D, 8'hC0, 8'h76, 8'h52, "xnor");

        // XOR accumulation up to DEPTH, then an ignored fire, then a fresh load
        pulse(8'h36, 8'h80, 8'h52, 8'h76, "acc_load");
        pulse(8'h4F, 8'h80, 8'h76, 8'h79, "fold1");
        pulse(8'h4F, 8'h80, 8'h79, 8'h76, "fold2");
        pulse(8'h4F, 8'h80, 8'h76, 8'hF9, "fold3_done");
        pulse(8'h4F, 8'h80, 8'hF9, 8'hF9, "fold_full_hold");
        pulse(8'h2D, 8'h1B, 8'hF9, 8'h49, "reload_clears_done");

        // Long strobe: operands toggle after the sampling edge, exactly one update expected
        @(negedge clk);
        pins.ui_in  = 8'h15;
        pins.uio_in = 8'h4C;
        repeat (3) @(negedge clk);
        pins.ui_in[7] = 1'b1;
        c = cyc;
        push(c + 2, 8'h49, "long_pre");
        push(c + 3, 8'h5D, "long_update");
        push(c + 6, 8'h5D, "long_hold6");
        push(c + 10, 8'h5D, "long_hold10");
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                pins.ui_in[5:0]  = pins.ui_in[5:0] ^ 6'h3F;
                pins.uio_in[5:0] = pins.uio_in[5:0] ^ 6'h3F;
            end
        end
        pins.ui_in[7] = 1'b0;
        push(cyc + 3, 8'h5D, "long_after_fall");
        repeat (4) @(negedge clk);

        // Strobe high across reset release must not fire
        @(negedge clk);
        pins.ui_in  = 8'hAD;
        pins.uio_in = 8'h5B;
        rst_n       = 1'b0;
        c = cyc;
        push(c + 1, 8'h00, "rsthi_r1");
        push(c + 2, 8'h00, "rsthi_r2");
        push(c + 4, 8'h00, "rsthi_hold4");
        push(c + 6, 8'h00, "rsthi_hold6");
        push(c + 8, 8'h00, "rsthi_hold8");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        pins.ui_in[7] = 1'b0;
        pulse(8'h2D, 8'h5B, 8'h00, 8'h7F, "rsthi_fresh_edge");

        // Reset mid-sequence (cnt=2), then fold from the cleared state
        pulse(8'h2D, 8'h1B, 8'h7F, 8'h49, "mid_load");
        pulse(8'h46, 8'h40, 8'h49, 8'h4F, "mid_fold");
        do_reset("mid_reset");
        pulse(8'h45, 8'h40, 8'h00, 8'h45, "post_rst_fold");
        pulse(8'h40, 8'h40, 8'h45, 8'h45, "post_rst_cnt2");
        pulse(8'h40, 8'h40, 8'h45, 8'h45, "post_rst_cnt3");
        pulse(8'h40, 8'h40, 8'h45, 8'hC5, "post_rst_cnt4_done");

        repeat (5) @(negedge clk);
        n_tests = n_tests + 1;
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d checks still pending, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tt_um_logic_accumulator.md
# tt_um_logic_accumulator

Parametrised, registered successor to the team's combinational AND/OR selector. It applies one of four bitwise operations (AND, OR, XOR, XNOR) to two operands on a synchronised strobe edge. It can also fold a stream of operands into a held result over a bounded number of samples. It is a Tiny Tapeout user tile; operands arrive on the dedicated and bidirectional input pins, and the result, valid and done flags drive the dedicated outputs.

## Interface
Parameters:
- WIDTH, 6, operand/result width; legal 1..6; unused upper result bits read 0.
- DEPTH, 4, maximum samples in one accumulation sequence (load + folds); legal 2..15.

Ports:
- clk  input  1  clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset; takes effect only on a rising edge of clk.
- ena  input  1  always 1 when powered; ignored.
- ui_in  input  8  [WIDTH-1:0] operand A; [6] acc (0 = load, 1 = fold); [7] strobe (asynchronous to clk).
- uio_in  input  8  [WIDTH-1:0] operand B; [7:6] mode (00 AND, 01 OR, 10 XOR, 11 XNOR).
- uo_out  output  8  [WIDTH-1:0] res; [6] valid; [7] done; other bits 0.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0; all uio pins are inputs.

## Operation
- Strobe path:
  - ui_in[7] passes through a two-flop synchroniser (s1, s2) followed by a history flop (prev).
  - fire = s2 & ~prev, one cycle wide per rising edge.
- op(x, y) is chosen by mode:
  - AND: x & y
  - OR: x | y
  - XOR: x ^ y
  - XNOR: ~(x ^ y), masked to WIDTH bits.
- mode, acc, A and B are sampled directly from the pins in the fire cycle. They must be stable for at least 3 cycles before the strobe rises. Changes while the strobe is high have no effect.
- On fire with acc = 0 (load):
  - res <= op(A, B)
  - cnt <= 1
  - valid <= 1
- On fire with acc = 1 and cnt < DEPTH (fold):
  - res <= op(res, A); B is ignored.
  - cnt <= cnt + 1
  - valid <= 1
- On fire with acc = 1 and cnt == DEPTH: the fire is ignored and res and cnt hold.
- A fold with cnt == 0 (after reset, before any load) operates on res = 0 and sets cnt to 1.
- done = (cnt == DEPTH), combinational from the cnt register.
- valid is sticky; only reset clears it.
- Mode may change between fires. Each fire uses the mode present in its own fire cycle.
- cnt width is the minimum needed to hold DEPTH.

## Timing
- Reset (rst_n low at a clk edge):
  - res = 0, cnt = 0, valid = 0.
  - s1 = s2 = prev = 1.
  - Resulting outputs: uo_out = 0x00, uio_out = 0x00, uio_oe = 0x00.
- Presetting the synchroniser to 1 means a strobe held high across reset release does not fire. A fresh low-to-high transition is required.
- Latency: if the strobe is first sampled high at edge k, fire is asserted between edges k+1 and k+2, and res, cnt, valid and done update at edge k+2.
- One strobe pulse gives exactly one fire, however long it is held high.
- Minimum strobe low time and high time is 3 cycles each. Shorter pulses may be missed, but never produce a double fire.
- If reset coincides with fire, reset wins and no update occurs.
- Reset in the middle of a sequence discards the accumulation; the next fire behaves as described for the post-reset state.
- No combinational path from any input to uo_out.

## Test plan
- Reset: hold rst_n low 2 cycles with arbitrary inputs -> uo_out = 0x00, uio_out = 0x00, uio_oe = 0x00.
- Single ops (WIDTH 6, DEPTH 4), A = 0x2D, B = 0x1B, acc = 0, one strobe per mode:
  - AND -> res 0x09
  - OR -> res 0x3F
  - XOR -> res 0x36
  - XNOR with B = 0x00 -> res 0x12
  - After each: valid = 1, done = 0; each result appears exactly 2 edges after the first high sample of the strobe.
- XOR accumulation:
  - Load A = 0x36, B = 0x00 -> res 0x36.
  - Three folds with A = 0x0F -> res 0x39, 0x36, 0x39; done = 1 after the third fold.
  - A fifth strobe -> res stays 0x39, done stays 1.
  - A subsequent load -> done = 0.
- Strobe held high 10 cycles while A and B toggle every cycle -> exactly one update, using values stable before the edge.
- Strobe high before and through rst_n release -> no update, uo_out stays 0x00 until the strobe goes low and rises again.
- Reset asserted mid-sequence (cnt = 2) -> uo_out = 0x00. A following fold with A = 0x05, mode OR -> res 0x05, cnt 1, valid = 1.
